// File: rtl/voq_mgr_pkg.sv
// voq_mgr_pkg: shared defaults, pointer width helper and drop count type for voq_mgr
package voq_mgr_pkg;
    localparam int EGRESS_CNT_DEF = 4;
    localparam int PACKET_CNT_DEF = 1024;
    localparam int META_WIDTH_DEF = 32;
    typedef logic [15:0] drop_cnt_t;
    function automatic int ptr_w(input int packet_cnt);
        return $clog2(packet_cnt) + 1;
    endfunction
endpackage

// File: rtl/simple_dual_port_mem.sv
// simple_dual_port_mem: one write port, one registered read port, no reset on contents
module simple_dual_port_mem #(
    parameter int MEM_SIZE = 1024,
    parameter int DATA_WIDTH = 32,
    localparam int AW = $clog2(MEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/voq_ptr.sv
// voq_ptr: lap-bit ring pointers and status for one VOQ (drop counter with VOQ_MGR_DROP_CNT_EN)
module voq_ptr import voq_mgr_pkg::*; #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc_wr,
    input  logic          inc_rd,
    input  logic          flush,
`ifdef VOQ_MGR_DROP_CNT_EN
    input  logic          drop,
    output drop_cnt_t     drop_cnt,
`endif
    output logic [CW-2:0] wr_idx,
    output logic [CW-2:0] rd_idx,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] occ
);
    localparam logic [CW-1:0] ONE = 1;
    localparam logic [CW-1:0] LAP = {1'b1, {(CW-1){1'b0}}};
    logic [CW-1:0] rd_ptr, wr_ptr;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (inc_wr) wr_ptr <= wr_ptr + ONE;
            if (flush) rd_ptr <= wr_ptr;
            else if (inc_rd) rd_ptr <= rd_ptr + ONE;
        end
    end
    assign wr_idx = wr_ptr[CW-2:0];
    assign rd_idx = rd_ptr[CW-2:0];
    assign empty  = rd_ptr == wr_ptr;
    assign full   = (rd_ptr ^ wr_ptr) == LAP;
    assign occ    = wr_ptr - rd_ptr;
`ifdef VOQ_MGR_DROP_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_cnt <= '0;
        else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
`endif
endmodule

// File: rtl/voq_mgr.sv
// voq_mgr: per-ingress VOQs on one shared memory; VOQ_MGR_DROP_CNT_EN adds per-VOQ drop counters
module voq_mgr import voq_mgr_pkg::*; #(
    parameter int EGRESS_CNT = EGRESS_CNT_DEF,
    parameter int PACKET_CNT = PACKET_CNT_DEF,
    parameter int META_WIDTH = META_WIDTH_DEF,
    localparam int SW = $clog2(EGRESS_CNT),
    localparam int CW = ptr_w(PACKET_CNT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enq_en,
    input  logic [SW-1:0]            enq_sel,
    input  logic [META_WIDTH-1:0]    enq_meta,
    output logic                     enq_accept,
    input  logic                     deq_en,
    input  logic [SW-1:0]            deq_sel,
    output logic                     deq_accept,
    output logic [META_WIDTH-1:0]    deq_meta,
    output logic                     deq_valid,
    input  logic                     flush_en,
    input  logic [SW-1:0]            flush_sel,
    output logic [EGRESS_CNT-1:0]    is_empty,
    output logic [EGRESS_CNT-1:0]    is_full,
    output logic [EGRESS_CNT*CW-1:0] occupancy
`ifdef VOQ_MGR_DROP_CNT_EN
    ,output logic [EGRESS_CNT*16-1:0] drop_cnt
`endif
);
    logic [CW-2:0] wr_idx [EGRESS_CNT];
    logic [CW-2:0] rd_idx [EGRESS_CNT];
    logic [META_WIDTH-1:0] rd_data;
    logic seen;
    assign enq_accept = enq_en && !is_full[enq_sel] && !(flush_en && flush_sel == enq_sel);
    assign deq_accept = deq_en && !is_empty[deq_sel] && !(flush_en && flush_sel == deq_sel);
    for (genvar k = 0; k < EGRESS_CNT; k++) begin : g_voq
        voq_ptr #(.CW(CW)) u_ptr (
            .clk      (clk),
            .reset    (reset),
            .inc_wr   (enq_accept && enq_sel == SW'(k)),
            .inc_rd   (deq_accept && deq_sel == SW'(k)),
            .flush    (flush_en && flush_sel == SW'(k)),
`ifdef VOQ_MGR_DROP_CNT_EN
            .drop     (enq_en && !enq_accept && enq_sel == SW'(k)),
            .drop_cnt (drop_cnt[k*16 +: 16]),
`endif
            .wr_idx   (wr_idx[k]),
            .rd_idx   (rd_idx[k]),
            .empty    (is_empty[k]),
            .full     (is_full[k]),
            .occ      (occupancy[k*CW +: CW])
        );
    end
    simple_dual_port_mem #(.MEM_SIZE(EGRESS_CNT*PACKET_CNT), .DATA_WIDTH(META_WIDTH)) u_mem (
        .clk     (clk),
        .wr_en   (enq_accept),
        .wr_addr ({enq_sel, wr_idx[enq_sel]}),
        .wr_data (enq_meta),
        .rd_en   (deq_accept),
        .rd_addr ({deq_sel, rd_idx[deq_sel]}),
        .rd_data (rd_data)
    );
    // The read register has no reset, so deq_meta is masked until a dequeue lands after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deq_valid <= 1'b0;
            seen      <= 1'b0;
        end else begin
            deq_valid <= deq_accept;
            seen      <= seen | deq_accept;
        end
    end
    assign deq_meta = seen ? rd_data : '0;
endmodule

// File: tb/tb_voq_mgr.sv
// tb_voq_mgr: directed checks of voq_mgr with 4 VOQs of 8 entries
module tb_voq_mgr;
    localparam int CW = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enq_en = 1'b0, deq_en = 1'b0, flush_en = 1'b0;
    logic [1:0] enq_sel = '0, deq_sel = '0, flush_sel = '0;
    logic [31:0] enq_meta = '0;
    logic enq_accept, deq_accept, deq_valid;
    logic [31:0] deq_meta;
    logic [3:0] is_empty, is_full;
    logic [4*CW-1:0] occupancy;
`ifdef VOQ_MGR_DROP_CNT_EN
    logic [63:0] drop_cnt;
`endif
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    voq_mgr #(.EGRESS_CNT(4), .PACKET_CNT(8), .META_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .enq_en(enq_en), .enq_sel(enq_sel), .enq_meta(enq_meta), .enq_accept(enq_accept),
        .deq_en(deq_en), .deq_sel(deq_sel), .deq_accept(deq_accept),
        .deq_meta(deq_meta), .deq_valid(deq_valid),
        .flush_en(flush_en), .flush_sel(flush_sel),
        .is_empty(is_empty), .is_full(is_full), .occupancy(occupancy)
`ifdef VOQ_MGR_DROP_CNT_EN
        ,.drop_cnt(drop_cnt)
`endif
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] occ(input int k);
        return 32'(occupancy[k*CW +: CW]);
    endfunction
    task automatic cyc(input logic ee, input logic [1:0] es, input logic [31:0] em,
                       input logic de, input logic [1:0] ds, input logic fe, input logic [1:0] fs,
                       input logic xe, input logic xd, input string tag);
        @(negedge clk);
        enq_en = ee; enq_sel = es; enq_meta = em;
        deq_en = de; deq_sel = ds; flush_en = fe; flush_sel = fs;
        #1;
        if (ee) chk({tag, " enq_accept"}, 32'(enq_accept), 32'(xe));
        if (de) chk({tag, " deq_accept"}, 32'(deq_accept), 32'(xd));
        @(posedge clk);
        #1;
        enq_en = 1'b0; deq_en = 1'b0; flush_en = 1'b0;
    endtask
    task automatic enq(input logic [1:0] s, input logic [31:0] m, input logic xe);
        cyc(1'b1, s, m, 1'b0, 2'd0, 1'b0, 2'd0, xe, 1'b0, "enq");
    endtask
    task automatic deq(input logic [1:0] s, input logic [31:0] m);
        cyc(1'b0, 2'd0, 32'd0, 1'b1, s, 1'b0, 2'd0, 1'b0, 1'b1, "deq");
        chk("deq_valid", 32'(deq_valid), 32'd1);
        chk("deq_meta", deq_meta, m);
    endtask
    initial begin
        #12;
        chk("rst is_empty", 32'(is_empty), 32'hF);
        chk("rst is_full", 32'(is_full), 32'h0);
        chk("rst occupancy", 32'(occupancy), 32'h0);
        chk("rst deq_valid", 32'(deq_valid), 32'h0);
        chk("rst deq_meta", deq_meta, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        // ordering
        enq(2'd2, 32'h11, 1'b1);
        enq(2'd2, 32'h22, 1'b1);
        enq(2'd2, 32'h33, 1'b1);
        chk("order occ2", occ(2), 32'd3);
        deq(2'd2, 32'h11);
        deq(2'd2, 32'h22);
        deq(2'd2, 32'h33);
        chk("order empty2", 32'(is_empty[2]), 32'd1);
        cyc(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, "idle");
        chk("idle deq_valid", 32'(deq_valid), 32'd0);
        chk("hold deq_meta", deq_meta, 32'h33);
        // fill and overflow
        for (int i = 0; i < 8; i++) enq(2'd1, 32'h100 + 32'(i), 1'b1);
        chk("fill full1", 32'(is_full[1]), 32'd1);
        chk("fill occ1", occ(1), 32'd8);
        enq(2'd1, 32'h1FF, 1'b0);
        chk("ovf occ1", occ(1), 32'd8);
`ifdef VOQ_MGR_DROP_CNT_EN
        chk("ovf drop1", 32'(drop_cnt[16 +: 16]), 32'd1);
`endif
        for (int i = 0; i < 8; i++) deq(2'd1, 32'h100 + 32'(i));
        chk("drain empty1", 32'(is_empty[1]), 32'd1);
        // simultaneous on full and on empty VOQ
        for (int i = 0; i < 8; i++) enq(2'd0, 32'h200 + 32'(i), 1'b1);
        cyc(1'b1, 2'd0, 32'h2FF, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, "sim full");
        chk("sim full meta", deq_meta, 32'h200);
        chk("sim full occ0", occ(0), 32'd7);
`ifdef VOQ_MGR_DROP_CNT_EN
        chk("sim full drop0", 32'(drop_cnt[0 +: 16]), 32'd1);
`endif
        cyc(1'b1, 2'd3, 32'h300, 1'b1, 2'd3, 1'b0, 2'd0, 1'b1, 1'b0, "sim empty");
        chk("sim empty occ3", occ(3), 32'd1);
        chk("sim empty valid", 32'(deq_valid), 32'd0);
        cyc(1'b1, 2'd0, 32'h2AA, 1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, "sim mid");
        chk("sim mid meta", deq_meta, 32'h201);
        chk("sim mid occ0", occ(0), 32'd7);
        // wrap-around on VOQ 1 (pointers start at lap 1)
        for (int i = 0; i < 20; i++) begin
            enq(2'd1, 32'h500 + 32'(i), 1'b1);
            chk("wrap occ1 one", occ(1), 32'd1);
            deq(2'd1, 32'h500 + 32'(i));
            chk("wrap occ1 zero", occ(1), 32'd0);
        end
        // flush
        for (int i = 1; i < 5; i++) enq(2'd3, 32'h300 + 32'(i), 1'b1);
        chk("flush pre occ3", occ(3), 32'd5);
        cyc(1'b1, 2'd0, 32'h2BB, 1'b1, 2'd3, 1'b1, 2'd3, 1'b1, 1'b0, "flush deq");
        chk("flush empty3", 32'(is_empty[3]), 32'd1);
        chk("flush occ3", occ(3), 32'd0);
        chk("flush occ0", occ(0), 32'd8);
        chk("flush valid", 32'(deq_valid), 32'd0);
        cyc(1'b1, 2'd3, 32'h3FF, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 1'b0, "flush enq");
        chk("flush is_empty", 32'(is_empty), 32'hE);
        chk("flush is_full", 32'(is_full), 32'h1);
`ifdef VOQ_MGR_DROP_CNT_EN
        chk("flush drop3", 32'(drop_cnt[48 +: 16]), 32'd1);
`endif
        // async reset while a dequeue is being requested
        @(negedge clk);
        deq_en = 1'b1; deq_sel = 2'd0;
        #1;
        chk("pre-rst deq_accept", 32'(deq_accept), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst is_empty", 32'(is_empty), 32'hF);
        chk("arst occupancy", 32'(occupancy), 32'h0);
        chk("arst deq_meta", deq_meta, 32'h0);
        chk("arst deq_accept", 32'(deq_accept), 32'd0);
        @(posedge clk);
        #1;
        chk("arst deq_valid", 32'(deq_valid), 32'd0);
        deq_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post-rst deq_valid", 32'(deq_valid), 32'd0);
        chk("post-rst deq_meta", deq_meta, 32'h0);
`ifdef VOQ_MGR_DROP_CNT_EN
        chk("post-rst drop_cnt", 32'(drop_cnt[31:0] | drop_cnt[63:32]), 32'h0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/voq_mgr.md
# voq_mgr

Parametrised virtual output queue manager for each ingress port: one ring-buffer VOQ per egress, all backed by one shared dual-port memory. Each entry holds one packet descriptor; for a packet this is the cmu ctrl address of its first segment. The block adds the following to the per-ingress queueing path:
- accept/reject handshakes
- full-capacity queues
- per-VOQ occupancy counters
- per-VOQ flush
- optional per-VOQ drop counters

The scheduler reads its state flags; the ingress datapath enqueues into it and the crossbar feeder dequeues from it.

## Interface
Parameters:
- EGRESS_CNT, 4: number of VOQs; must be at least 2.
- PACKET_CNT, 1024: entries per VOQ; must be a power of 2.
- META_WIDTH, 32: descriptor width in bits.

Ports (SW = $clog2(EGRESS_CNT), CW = $clog2(PACKET_CNT)+1):
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- enq_en  in  1  enqueue request.
- enq_sel  in  SW  target VOQ.
- enq_meta  in  META_WIDTH  descriptor to store.
- enq_accept  out  1  combinational; enqueue is taken this cycle.
- deq_en  in  1  dequeue request.
- deq_sel  in  SW  source VOQ.
- deq_accept  out  1  combinational; dequeue is taken this cycle.
- deq_meta  out  META_WIDTH  head descriptor of the last accepted dequeue.
- deq_valid  out  1  one-cycle pulse qualifying deq_meta.
- flush_en  in  1  discard the whole content of one VOQ.
- flush_sel  in  SW  VOQ to flush.
- is_empty  out  EGRESS_CNT  per-VOQ empty flag.
- is_full  out  EGRESS_CNT  per-VOQ full flag (occupancy == PACKET_CNT).
- occupancy  out  EGRESS_CNT*CW  flattened per-VOQ count; VOQ k is at [k*CW +: CW].
- drop_cnt  out  EGRESS_CNT*16  flattened per-VOQ rejected-enqueue counts; present only with VOQ_MGR_DROP_CNT_EN.

## Operation
- **Pointers:** each VOQ has rd_ptr and wr_ptr, each CW bits wide. The low CW-1 bits index the entry; the MSB is a lap bit.
- **Physical address:** {sel, ptr[CW-2:0]}. Memory depth is EGRESS_CNT*PACKET_CNT.
- **Status decode:** empty when rd_ptr == wr_ptr. Full when the pointers differ only in the MSB. Occupancy = wr_ptr - rd_ptr, modulo 2^CW. Full capacity is PACKET_CNT entries, with no wasted slot. Pointers wrap naturally on overflow.
- **Enqueue:** enq_accept = enq_en && !is_full[enq_sel] && !(flush_en && flush_sel == enq_sel). On accept, memory is written at wr_ptr and wr_ptr increments. Nothing is written when the enqueue is rejected.
- **Dequeue:** deq_accept = deq_en && !is_empty[deq_sel] && !(flush_en && flush_sel == deq_sel). On accept, memory is read at rd_ptr and rd_ptr increments.
- **Flush:** rd_ptr[flush_sel] <= wr_ptr[flush_sel]. Flush overrides an enqueue or dequeue on the same VOQ in the same cycle; both are rejected. Operations on other VOQs proceed normally.
- **Same VOQ, enqueue and dequeue in one cycle:**
  - Both are accepted if the VOQ is neither empty nor full; occupancy is unchanged.
  - If the VOQ is empty, only the enqueue is accepted. There is no bypass.
  - If the VOQ is full, only the dequeue is accepted. The read address and write address therefore never collide.
- **Different VOQs:** enqueue and dequeue are fully independent.
- **Reset:** all pointers clear to 0, so is_empty is all ones. is_full = 0, occupancy = 0, deq_valid = 0, deq_meta = 0, drop_cnt = 0. Memory contents are not cleared. A reset asserted mid-operation discards all queued descriptors and any read in flight.

## Timing
- enq_accept and deq_accept are valid in the same cycle as their requests.
- Pointer, flag and occupancy updates are visible after the next rising edge.
- Read latency is 1 cycle: a dequeue accepted in cycle N gives deq_valid = 1 and deq_meta in cycle N+1. deq_meta holds its value until the next accepted dequeue.
- An enqueue in cycle N into an empty VOQ can be dequeued in cycle N+1, with data in N+2.
- Back-to-back accepted dequeues sustain one descriptor per cycle.

## Configuration
- **VOQ_MGR_DROP_CNT_EN defined:**
  - Each VOQ has a 16-bit saturating counter.
  - It increments when enq_en targets that VOQ and enq_accept = 0 (full or flushed).
  - It holds at 16'hFFFF and clears on reset.
- **Undefined:** the drop_cnt port and the counters do not exist; all other behaviour is identical.

## Structure
- **Package voq_mgr_pkg:**
  - Default parameter constants.
  - Function ptr_w(PACKET_CNT) returning $clog2(PACKET_CNT)+1.
  - Typedef for the 16-bit drop count.
- **Sub-module voq_ptr:** one instance per VOQ, generated EGRESS_CNT times.
  - Holds rd_ptr and wr_ptr with inc/flush inputs.
  - Outputs empty, full and occupancy.
  - Holds the drop counter under the macro.
- **Storage:** the existing simple_dual_port_mem with MEM_SIZE = EGRESS_CNT*PACKET_CNT and DATA_WIDTH = META_WIDTH, with a registered read.

## Test plan
Scenarios use PACKET_CNT = 8 unless stated otherwise.
- **Ordering:** enqueue 0x11, 0x22, 0x33 to VOQ 2, then dequeue 3 times → deq_meta = 0x11, 0x22, 0x33, each 1 cycle after deq_accept; is_empty[2] = 1 at the end.
- **Fill and overflow:** 8 enqueues to VOQ 1 → is_full[1] = 1 and occupancy = 8; a 9th enqueue → enq_accept = 0 and the contents are unchanged; drop_cnt[1] = 1 with the macro.
- **Simultaneous:** VOQ 0 full, enqueue and dequeue on VOQ 0 in one cycle → only the dequeue is accepted and occupancy = 7. VOQ 3 empty, enqueue and dequeue on VOQ 3 in one cycle → only the enqueue is accepted and occupancy = 1.
- **Wrap-around:** 20 interleaved enqueue/dequeue pairs on VOQ 1 → the data order is preserved and occupancy never exceeds 1.
- **Flush:** 5 entries in VOQ 3; flush_en with a dequeue to VOQ 3 in the same cycle → deq_accept = 0, then is_empty[3] = 1; the other VOQs are unchanged.
- **Async reset:** reset asserted between clock edges while a dequeue is in flight → outputs clear immediately and deq_valid stays 0.
